apb_pad_ctrl: RTL and testbench

Parametrised APB pad-control slave, the next generation of the PULPino pad mux/config register block. Pad count, config width and mux width are parametrised. Software writes a shadow register bank, then commits it atomically through an isolation sequence, so the pad frame never sees a half-updated configuration. A sticky lock freezes the configuration until reset. Sits on the peripheral APB bus and drives the pad frame directly.

---
 rtl/apb_pad_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_apb_pad_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_pad_ctrl.sv
// rtl/apb_pad_ctrl.sv - APB pad mux/config slave with shadow bank and isolated atomic commit
module apb_pad_ctrl #(
   parameter int APB_ADDR_WIDTH = 12,
   parameter int N_PADS         = 32,
   parameter int CFG_WIDTH      = 6,
   parameter int MUX_WIDTH      = 2,
   parameter int ISO_CYCLES     = 4
) (
   input  logic                          HCLK,
   input  logic                          HRESETn,
   input  logic [APB_ADDR_WIDTH-1:0]     PADDR,
   input  logic [31:0]                   PWDATA,
   input  logic                          PWRITE,
   input  logic                          PSEL,
   input  logic                          PENABLE,
   output logic [31:0]                   PRDATA,
   output logic                          PREADY,
   output logic                          PSLVERR,
   output logic [N_PADS*MUX_WIDTH-1:0]   pad_mux_o,
   output logic [N_PADS*CFG_WIDTH-1:0]   pad_cfg_o,
   output logic                          pad_iso_o,
   output logic                          cfg_lock_o
);

   localparam int AW = APB_ADDR_WIDTH;

   typedef enum logic [1:0] {
      IDLE,
      ISO_ON,
      APPLY,
      ISO_OFF
   } state_t;

   state_t         state;
   state_t         state_nx;
   logic [7:0]     iso_cnt;
   logic [7:0]     iso_cnt_nx;
   logic           apply;
   logic           commit_done;
   logic           lock;
   logic [15:0]    cnt;

   logic [MUX_WIDTH-1:0] shadow_mux [N_PADS];
   logic [CFG_WIDTH-1:0] shadow_cfg [N_PADS];
   logic [MUX_WIDTH-1:0] active_mux [N_PADS];
   logic [CFG_WIDTH-1:0] active_cfg [N_PADS];

   logic [AW-1:0]  word_addr;
   logic [AW-9:0]  page;
   logic [5:0]     pad_idx;
   logic           idx_ok;
   logic           access;
   logic           busy;
   logic           sel_ctrl;
   logic           sel_info;
   logic           sel_cnt;
   logic           sel_shadow;
   logic           sel_active;
   logic           held;
   logic           wr_en;
   logic           lock_err;
   logic           commit_go;
   logic           lock_set;
   logic           shadow_we;
   logic [31:0]    rdata;
   logic           unused_bits;

   assign word_addr  = {PADDR[AW-1:2], 2'b00};
   assign page       = PADDR[AW-1:8];
   assign pad_idx    = PADDR[7:2];
   assign idx_ok     = ({1'b0, pad_idx} < 7'(N_PADS));
   assign access     = PSEL & PENABLE;
   assign busy       = (state != IDLE);

   assign sel_ctrl   = (word_addr == AW'('h000));
   assign sel_info   = (word_addr == AW'('h004));
   assign sel_cnt    = (word_addr == AW'('h008));
   assign sel_shadow = (page == (AW-8)'(1)) & idx_ok;
   assign sel_active = (page == (AW-8)'(2)) & idx_ok;

   // Writes that could disturb a commit in flight are stalled, not dropped
   assign held       = access & PWRITE & (sel_ctrl | sel_shadow) & busy;
   assign wr_en      = access & PWRITE & ~held;
   assign lock_err   = wr_en & lock & (sel_shadow | (sel_ctrl & PWDATA[0]));
   assign commit_go  = wr_en & sel_ctrl & PWDATA[0] & ~lock;
   assign lock_set   = wr_en & sel_ctrl & PWDATA[1] & ~lock_err;
   assign shadow_we  = wr_en & sel_shadow & ~lock;

   assign PREADY     = ~held;
   assign PSLVERR    = lock_err;
   assign pad_iso_o  = busy;
   assign cfg_lock_o = lock;
   assign unused_bits = ^{PADDR[1:0], PWDATA};

   always_comb begin
      rdata = '0;
      if (sel_ctrl) begin
         rdata = {30'b0, lock, busy};
      end else if (sel_info) begin
         rdata = {8'd2, 8'(MUX_WIDTH), 8'(CFG_WIDTH), 8'(N_PADS)};
      end else if (sel_cnt) begin
         rdata = {16'b0, cnt};
      end
      for (int i = 0; i < N_PADS; i++) begin
         if (sel_shadow && (pad_idx == 6'(i))) begin
            rdata = (32'(shadow_cfg[i]) << 8) | 32'(shadow_mux[i]);
         end
         if (sel_active && (pad_idx == 6'(i))) begin
            rdata = (32'(active_cfg[i]) << 8) | 32'(active_mux[i]);
         end
      end
   end

   assign PRDATA = (access & ~PWRITE) ? rdata : 32'b0;

   always_comb begin
      state_nx    = state;
      iso_cnt_nx  = iso_cnt;
      apply       = 1'b0;
      commit_done = 1'b0;
      case (state)
         IDLE: begin
            if (commit_go) begin
               iso_cnt_nx = 8'(ISO_CYCLES - 1);
               state_nx   = ISO_ON;
            end
         end
         ISO_ON: begin
            if (iso_cnt == 8'd0) begin
               state_nx = APPLY;
            end else begin
               iso_cnt_nx = iso_cnt - 8'd1;
            end
         end
         APPLY: begin
            apply      = 1'b1;
            iso_cnt_nx = 8'(ISO_CYCLES - 1);
            state_nx   = ISO_OFF;
         end
         ISO_OFF: begin
            if (iso_cnt == 8'd0) begin
               state_nx    = IDLE;
               commit_done = 1'b1;
            end else begin
               iso_cnt_nx = iso_cnt - 8'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state   <= IDLE;
         iso_cnt <= '0;
         lock    <= 1'b0;
         cnt     <= '0;
      end else begin
         state   <= state_nx;
         iso_cnt <= iso_cnt_nx;
         if (lock_set) begin
            lock <= 1'b1;
         end
         if (commit_done) begin
            cnt <= cnt + 16'd1;
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < N_PADS; i++) begin
            shadow_mux[i] <= '0;
            shadow_cfg[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_PADS; i++) begin
            if (shadow_we && (pad_idx == 6'(i))) begin
               shadow_mux[i] <= PWDATA[MUX_WIDTH-1:0];
               shadow_cfg[i] <= PWDATA[8+CFG_WIDTH-1:8];
            end
         end
      end
   end

   // Every pad takes its shadow value on the single APPLY edge
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         for (int i = 0; i < N_PADS; i++) begin
            active_mux[i] <= '0;
            active_cfg[i] <= '0;
         end
      end else if (apply) begin
         for (int i = 0; i < N_PADS; i++) begin
            active_mux[i] <= shadow_mux[i];
            active_cfg[i] <= shadow_cfg[i];
         end
      end
   end

   for (genvar g = 0; g < N_PADS; g++) begin : g_pad
      assign pad_mux_o[g*MUX_WIDTH +: MUX_WIDTH] = active_mux[g];
      assign pad_cfg_o[g*CFG_WIDTH +: CFG_WIDTH] = active_cfg[g];
   end

endmodule

// File: tb/tb_apb_pad_ctrl.sv
// tb/tb_apb_pad_ctrl.sv - scoreboard bench for apb_pad_ctrl with default parameters
module tb_apb_pad_ctrl;

   logic          HCLK;
   logic          HRESETn;
   logic [11:0]   PADDR;
   logic [31:0]   PWDATA;
   logic          PWRITE;
   logic          PSEL;
   logic          PENABLE;
   logic [31:0]   PRDATA;
   logic          PREADY;
   logic          PSLVERR;
   logic [63:0]   pad_mux_o;
   logic [191:0]  pad_cfg_o;
   logic          pad_iso_o;
   logic          cfg_lock_o;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic        is_read;
      logic [31:0] data;
      logic        err;
      string       name;
   } exp_t;

   exp_t sb[$];

   localparam logic [63:0]  MUX_P3 = 64'h40;
   localparam logic [191:0] CFG_P3 = 192'h2A << 18;

   apb_pad_ctrl dut (
      .HCLK       (HCLK),
      .HRESETn    (HRESETn),
      .PADDR      (PADDR),
      .PWDATA     (PWDATA),
      .PWRITE     (PWRITE),
      .PSEL       (PSEL),
      .PENABLE    (PENABLE),
      .PRDATA     (PRDATA),
      .PREADY     (PREADY),
      .PSLVERR    (PSLVERR),
      .pad_mux_o  (pad_mux_o),
      .pad_cfg_o  (pad_cfg_o),
      .pad_iso_o  (pad_iso_o),
      .cfg_lock_o (cfg_lock_o)
   );

   initial HCLK = 1'b0;
   always #5 HCLK = ~HCLK;

   always @(negedge HCLK) begin
      if (HRESETn && PSEL && PENABLE && PREADY) begin
         checks++;
         if (sb.size() == 0) begin
            failures++;
            $display("FAIL unexpected_transfer addr=%h", PADDR);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ((e.is_read && (PRDATA !== e.data)) || (PSLVERR !== e.err)) begin
               failures++;
               $display("FAIL %s got data=%h err=%b want data=%h err=%b",
                        e.name, PRDATA, PSLVERR, e.data, e.err);
            end
         end
      end
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h want=%h", nm, act, exp);
      end
   endtask

   task automatic apb(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                      input logic [31:0] exp_data, input logic exp_err, input string nm,
                      output int waits);
      exp_t e;
      e.is_read = ~wr;
      e.data    = exp_data;
      e.err     = exp_err;
      e.name    = nm;
      sb.push_back(e);
      @(posedge HCLK); #1;
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
      @(posedge HCLK); #1;
      PENABLE = 1'b1;
      waits = 0;
      @(negedge HCLK);
      while (!PREADY && waits < 100) begin
         waits++;
         @(negedge HCLK);
      end
      if (!PREADY) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout waits=%0d limit=100", nm, waits);
         sb.delete();
      end
      @(posedge HCLK); #1;
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic wr(input logic [11:0] addr, input logic [31:0] d, input logic err, input string nm);
      int w;
      apb(1'b1, addr, d, 32'h0, err, nm, w);
   endtask

   task automatic rd(input logic [11:0] addr, input logic [31:0] exp, input string nm);
      int w;
      apb(1'b0, addr, 32'h0, exp, 1'b0, nm, w);
   endtask

   task automatic wait_idle(input string nm);
      int n = 0;
      while (pad_iso_o && n < 100) begin
         @(negedge HCLK);
         n++;
      end
      chk(nm, pad_iso_o, 0);
   endtask

   task automatic do_reset();
      HRESETn = 1'b0;
      repeat (2) @(posedge HCLK);
      #1 HRESETn = 1'b1;
   endtask

   initial begin
      int waits;
      int iso_len;
      HRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0;
      do_reset();

      // reset state and read-only map
      @(negedge HCLK);
      chk("rst_iso", pad_iso_o, 0);
      chk("rst_lock", cfg_lock_o, 0);
      chk("rst_mux", pad_mux_o, 0);
      chk("rst_cfg", pad_cfg_o, 0);
      chk("rst_pready", PREADY, 1);
      chk("rst_pslverr", PSLVERR, 0);
      chk("rst_prdata", PRDATA, 0);
      rd(12'h004, 32'h0202_0620, "info");
      rd(12'h214, 32'h0, "active5_rst");
      rd(12'h000, 32'h0, "ctrl_rst");
      rd(12'h008, 32'h0, "cnt_rst");
      rd(12'h00C, 32'h0, "unmapped_rd");
      rd(12'h180, 32'h0, "shadow32_unmapped");
      wr(12'h004, 32'hFFFF_FFFF, 1'b0, "info_wr_ignored");
      rd(12'h004, 32'h0202_0620, "info_after_wr");

      // commit with pulse timing
      wr(12'h10C, 32'hFFFF_EA05, 1'b0, "shadow3_wr");
      rd(12'h10C, 32'h0000_2A01, "shadow3_rd");
      wr(12'h000, 32'h1, 1'b0, "ctrl_commit");
      iso_len = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge HCLK);
         if (k == 0) chk("iso_rise", pad_iso_o, 1);
         if (k == 4) chk("mux_before_apply", pad_mux_o, 0);
         if (k == 5) begin
            chk("mux_after_apply", pad_mux_o, MUX_P3);
            chk("cfg_after_apply", pad_cfg_o, CFG_P3);
         end
         if (pad_iso_o) iso_len++;
      end
      chk("iso_len", iso_len, 9);
      rd(12'h008, 32'h1, "cnt_one");
      rd(12'h000, 32'h0, "ctrl_idle");
      rd(12'h20C, 32'h0000_2A01, "active3");

      // write held off while busy
      wr(12'h000, 32'h1, 1'b0, "ctrl_commit2");
      apb(1'b1, 12'h100, 32'h0000_0302, 32'h0, 1'b0, "shadow0_held", waits);
      chk("held_waits", waits, 7);
      rd(12'h200, 32'h0, "active0_unchanged");
      rd(12'h100, 32'h0000_0302, "shadow0_rd");
      rd(12'h008, 32'h2, "cnt_two");
      chk("mux_unchanged", pad_mux_o, MUX_P3);

      // lock behaviour
      wr(12'h000, 32'h2, 1'b0, "ctrl_lock");
      chk("lock_out", cfg_lock_o, 1);
      wr(12'h104, 32'h0000_0101, 1'b1, "shadow1_locked");
      rd(12'h104, 32'h0, "shadow1_unchanged");
      wr(12'h000, 32'h1, 1'b1, "commit_locked");
      iso_len = 0;
      for (int k = 0; k < 12; k++) begin
         @(negedge HCLK);
         if (pad_iso_o) iso_len++;
      end
      chk("no_iso_locked", iso_len, 0);
      rd(12'h000, 32'h2, "ctrl_locked_rd");
      rd(12'h008, 32'h2, "cnt_locked");

      // commit and lock in one write
      do_reset();
      @(negedge HCLK);
      chk("rst2_lock", cfg_lock_o, 0);
      wr(12'h10C, 32'h0000_2A01, 1'b0, "shadow3_wr2");
      wr(12'h000, 32'h3, 1'b0, "ctrl_commit_lock");
      chk("combo_lock", cfg_lock_o, 1);
      chk("combo_iso", pad_iso_o, 1);
      wait_idle("combo_done");
      chk("combo_mux", pad_mux_o, MUX_P3);
      rd(12'h008, 32'h1, "combo_cnt");
      rd(12'h000, 32'h2, "combo_ctrl");

      // reset during APPLY
      do_reset();
      wr(12'h10C, 32'h0000_2A01, 1'b0, "shadow3_wr3");
      wr(12'h000, 32'h1, 1'b0, "ctrl_commit3");
      wait_idle("commit3_done");
      wr(12'h10C, 32'h0000_1502, 1'b0, "shadow3_wr4");
      wr(12'h000, 32'h3, 1'b0, "ctrl_commit4");
      repeat (5) @(negedge HCLK);
      chk("pre_rst_iso", pad_iso_o, 1);
      chk("pre_rst_mux", pad_mux_o, MUX_P3);
      chk("pre_rst_lock", cfg_lock_o, 1);
      HRESETn = 1'b0;
      #1;
      chk("midrst_iso", pad_iso_o, 0);
      chk("midrst_mux", pad_mux_o, 0);
      chk("midrst_cfg", pad_cfg_o, 0);
      chk("midrst_lock", cfg_lock_o, 0);
      chk("midrst_pready", PREADY, 1);
      @(posedge HCLK); #1 HRESETn = 1'b1;
      rd(12'h20C, 32'h0, "midrst_active3");
      rd(12'h008, 32'h0, "midrst_cnt");

      // counter wrap
      force dut.cnt = 16'hFFFF;
      @(negedge HCLK);
      release dut.cnt;
      rd(12'h008, 32'h0000_FFFF, "cnt_preset");
      wr(12'h000, 32'h1, 1'b0, "ctrl_commit_wrap");
      wait_idle("wrap_done");
      rd(12'h008, 32'h0, "cnt_wrap");

      repeat (2) @(negedge HCLK);
      chk("sb_empty", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
